mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch side and the data side of the pipeline.
- The data side is driven by the control unit's dmemREN/dmemWEN/datomic decode.
- A registered FSM grants one requester at a time, stalls the loser via its wait line, and prevents fetch starvation.
- Optionally implements the LL/SC link register for atomic data accesses.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/link_reg.sv | 47 ++++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, word type and memory-arbiter FSM state,
// plus the starvation-counter step function used by the arbiter.
package cpu_types_pkg;

  localparam int unsigned WordW   = 32;
  localparam int unsigned StarveW = 4;

  typedef logic [WordW-1:0]   word_t;
  typedef logic [StarveW-1:0] starve_cnt_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

  // Count data grants served while a fetch is waiting; any data grant with no
  // fetch pending means the fetch side is not being starved.
  function automatic starve_cnt_t starve_next(input starve_cnt_t cnt,
                                              input logic        fetch_pending,
                                              input starve_cnt_t limit);
    if (!fetch_pending) return '0;
    return (cnt >= limit) ? limit : cnt + starve_cnt_t'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of all mem_arbiter signals.
//   arb : arbiter view (requests/RAM response in, grants/loads out)
//   tb  : requester/RAM-model view (the mirror image)
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) (
  input logic CLK
);
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic              datomic;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
    output RST, iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate
  );
endinterface

// File: rtl/link_reg.sv
// LL/SC link register, only built when ATOMIC_LINK_EN is defined.
//   clk_i, rst_i : clock, synchronous active-high reset (link invalid)
//   ll_done_i    : a load-linked completed; capture addr_i and set valid
//   wr_done_i    : a write to addr_i completed; drops the link if it hits
//   addr_i       : current data address
//   link_ok_o    : link valid and addr_i matches the linked address
`ifdef ATOMIC_LINK_EN
module link_reg #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ll_done_i,
  input  logic              wr_done_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              link_ok_o
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_hit;

  assign addr_hit  = (addr_q == addr_i);
  assign link_ok_o = valid_q & addr_hit;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (ll_done_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end else if (wr_done_i && addr_hit) begin
      // Covers both a successful SC and a plain store to the linked word.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end
endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// A registered FSM (IDLE/IGRANT/DGRANT) grants one side at a time; the loser
// sees its wait line high. After MAX_DATA_GRANTS data grants with a fetch
// pending, the fetch is forced through.
// Optional macro ATOMIC_LINK_EN adds the LL/SC link register (link_reg).
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   iREN, iaddr / iload, iwait     fetch request and response
//   dREN, dWEN, datomic, daddr,
//   dstore / dload, dwait          data request and response (dload=1 on SC success)
//   ramREN, ramWEN, ramaddr,
//   ramstore / ramload, ramstate   RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned WORD_W          = 32,
  parameter int unsigned MAX_DATA_GRANTS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate
);
  localparam starve_cnt_t MaxGrants = starve_cnt_t'(MAX_DATA_GRANTS);

  arb_state_t  state_q, state_d;
  starve_cnt_t starve_q, starve_d;

  logic d_req, d_read, ram_ok, force_fetch;
  logic d_done, ll_done, wr_done;
  logic is_sc, sc_fail;

  assign d_req       = dREN | dWEN;
  assign d_read      = dREN & ~dWEN;  // read+write together counts as a write
  assign ram_ok      = (ramstate == ACCESS);
  assign force_fetch = iREN && (starve_q == MaxGrants);
  assign ll_done     = d_done & d_read & datomic;
  assign wr_done     = d_done & dWEN;

`ifdef ATOMIC_LINK_EN
  logic link_ok;

  assign is_sc   = dWEN & datomic;
  assign sc_fail = is_sc & ~link_ok;

  link_reg #(
    .ADDR_W(ADDR_W)
  ) u_link_reg (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ll_done_i(ll_done),
    .wr_done_i(wr_done),
    .addr_i   (daddr),
    .link_ok_o(link_ok)
  );
`else
  logic unused_link;

  assign is_sc       = 1'b0;
  assign sc_fail     = 1'b0;
  assign unused_link = ll_done ^ wr_done;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    d_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !force_fetch) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ok) begin
          iload    = ramload;
          iwait    = 1'b0;
          state_d  = IDLE;
          starve_d = '0;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else if (sc_fail) begin
          // Failed SC completes at once without touching the RAM.
          dwait    = 1'b0;
          state_d  = IDLE;
          starve_d = starve_next(starve_q, iREN, MaxGrants);
        end else begin
          ramWEN = dWEN;
          ramREN = d_read;
          if (ram_ok) begin
            d_done   = 1'b1;
            dwait    = 1'b0;
            state_d  = IDLE;
            starve_d = starve_next(starve_q, iREN, MaxGrants);
            if (d_read) begin
              dload = ramload;
            end else if (is_sc) begin
              dload[0] = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // No completion is reported while reset is held, whatever the RAM says.
    if (RST) begin
      iwait  = 1'b1;
      dwait  = 1'b1;
      iload  = '0;
      dload  = '0;
      d_done = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic [95:0] tag;
    logic        is_data;
    word_t       data;
  } exp_t;

  logic  clk;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  exp_t  mon_e;
  string mon_tag;

  mem_arbiter_if #(.ADDR_W(32), .WORD_W(32)) bus (.CLK(clk));

  mem_arbiter #(
    .ADDR_W         (32),
    .WORD_W         (32),
    .MAX_DATA_GRANTS(4)
  ) dut (
    .CLK     (clk),
    .RST     (bus.RST),
    .iREN    (bus.iREN),
    .iaddr   (bus.iaddr),
    .iload   (bus.iload),
    .iwait   (bus.iwait),
    .dREN    (bus.dREN),
    .dWEN    (bus.dWEN),
    .datomic (bus.datomic),
    .daddr   (bus.daddr),
    .dstore  (bus.dstore),
    .dload   (bus.dload),
    .dwait   (bus.dwait),
    .ramREN  (bus.ramREN),
    .ramWEN  (bus.ramWEN),
    .ramaddr (bus.ramaddr),
    .ramstore(bus.ramstore),
    .ramload (bus.ramload),
    .ramstate(bus.ramstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_d(input logic ren, input logic wen, input logic atom,
                         input logic [31:0] addr, input logic [31:0] store);
    bus.dREN    = ren;
    bus.dWEN    = wen;
    bus.datomic = atom;
    bus.daddr   = addr;
    bus.dstore  = store;
  endtask

  task automatic push(input logic [95:0] tag, input logic is_data, input word_t data);
    exp_t e;
    e.tag     = tag;
    e.is_data = is_data;
    e.data    = data;
    exp_q.push_back(e);
  endtask

  // Completion monitor: every wait-low cycle must match the next expected result.
  always @(negedge clk) begin
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {30'b0, bus.dwait, bus.iwait}, 32'd3);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_tag = $sformatf("%0s", mon_e.tag);
        chk({mon_tag, "_port"}, {30'b0, ~bus.dwait, ~bus.iwait}, mon_e.is_data ? 32'd2 : 32'd1);
        chk({mon_tag, "_load"}, mon_e.is_data ? bus.dload : bus.iload, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RST      = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    sample();
    chk("rst_iwait", {31'b0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'b0, bus.dwait}, 32'd1);
    chk("rst_ramREN", {31'b0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_iload", bus.iload, 32'd0);
    chk("rst_dload", bus.dload, 32'd0);

    // Fetch 0x40: two BUSY cycles then ACCESS; completes on cycle 4
    tick();
    bus.RST      = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h40;
    bus.ramload  = 32'hDEADBEEF;
    bus.ramstate = BUSY;
    push("fetch40", 1'b0, 32'hDEADBEEF);
    sample();
    chk("f_c1_ramREN", {31'b0, bus.ramREN}, 32'd0);
    for (int c = 2; c <= 3; c++) begin
      tick();
      sample();
      chk($sformatf("f_c%0d_ramREN", c), {31'b0, bus.ramREN}, 32'd1);
      chk($sformatf("f_c%0d_ramaddr", c), bus.ramaddr, 32'h40);
      chk($sformatf("f_c%0d_iwait", c), {31'b0, bus.iwait}, 32'd1);
    end
    tick();
    bus.ramstate = ACCESS;
    sample();
    chk("f_c4_ramREN", {31'b0, bus.ramREN}, 32'd1);
    chk("f_c4_iwait", {31'b0, bus.iwait}, 32'd0);
    tick();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    sample();
    chk("f_c5_iwait", {31'b0, bus.iwait}, 32'd1);
    chk("f_c5_ramREN", {31'b0, bus.ramREN}, 32'd0);

    // Starvation guard: 4 data grants then 1 fetch, twice
    tick();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h80;
    bus.ramload  = 32'h5A5A0001;
    bus.ramstate = ACCESS;
    drive_d(1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push("dgrant", 1'b1, 32'h5A5A0001);
      push("fgrant", 1'b0, 32'h5A5A0001);
    end
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    chk("starve_drain", exp_q.size(), 32'd0);
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Read+write together is a write
    tick();
    bus.ramstate = BUSY;
    drive_d(1'b1, 1'b1, 1'b0, 32'h100, 32'h5);
    push("wr100", 1'b1, 32'h0);
    sample();
    chk("rw_idle_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    tick();
    sample();
    chk("rw_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
    chk("rw_ramREN", {31'b0, bus.ramREN}, 32'd0);
    chk("rw_ramstore", bus.ramstore, 32'h5);
    chk("rw_ramaddr", bus.ramaddr, 32'h100);
    tick();
    bus.ramstate = ACCESS;
    sample();
    tick();
    bus.ramstate = FREE;
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Read retried through 3 ERROR cycles, single completion on ACCESS
    tick();
    bus.ramstate = ERROR;
    bus.ramload  = 32'hCAFEF00D;
    drive_d(1'b1, 1'b0, 1'b0, 32'h180, 32'h0);
    push("rd180", 1'b1, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      tick();
      sample();
      chk($sformatf("err%0d_ramREN", c), {31'b0, bus.ramREN}, 32'd1);
      chk($sformatf("err%0d_ramaddr", c), bus.ramaddr, 32'h180);
      chk($sformatf("err%0d_dwait", c), {31'b0, bus.dwait}, 32'd1);
    end
    tick();
    bus.ramstate = ACCESS;
    sample();
    tick();
    bus.ramstate = FREE;
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("err_after_dwait", {31'b0, bus.dwait}, 32'd1);

    // Reset in DGRANT while BUSY
    tick();
    bus.ramstate = BUSY;
    drive_d(1'b1, 1'b0, 1'b0, 32'h1C0, 32'h0);
    tick();
    sample();
    chk("rmid_ramREN_pre", {31'b0, bus.ramREN}, 32'd1);
    tick();
    bus.RST = 1'b1;
    sample();
    chk("rmid_dwait_rst", {31'b0, bus.dwait}, 32'd1);
    tick();
    bus.RST = 1'b0;
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    chk("rmid_ramREN", {31'b0, bus.ramREN}, 32'd0);
    chk("rmid_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    chk("rmid_dwait", {31'b0, bus.dwait}, 32'd1);
    chk("rmid_state", {30'b0, dut.state_q}, {30'b0, IDLE});

`ifdef ATOMIC_LINK_EN
    // LL 0x200 then SC 0x200 succeeds
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h77;
    drive_d(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    push("ll200", 1'b1, 32'h77);
    tick();
    tick();
    drive_d(1'b0, 1'b1, 1'b1, 32'h200, 32'hAB);
    push("sc_ok", 1'b1, 32'h1);
    tick();
    sample();
    chk("sc_ok_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
    chk("sc_ok_ramstore", bus.ramstore, 32'hAB);
    tick();

    // LL, plain write to the linked word, then SC fails without RAM access
    drive_d(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    push("ll200b", 1'b1, 32'h77);
    tick();
    tick();
    drive_d(1'b0, 1'b1, 1'b0, 32'h200, 32'h9);
    push("wr200", 1'b1, 32'h0);
    tick();
    tick();
    bus.ramstate = BUSY;
    drive_d(1'b0, 1'b1, 1'b1, 32'h200, 32'hCD);
    push("sc_fail", 1'b1, 32'h0);
    tick();
    sample();
    chk("sc_fail_ramWEN", {31'b0, bus.ramWEN}, 32'd0);
    chk("sc_fail_ramREN", {31'b0, bus.ramREN}, 32'd0);
    chk("sc_fail_dwait", {31'b0, bus.dwait}, 32'd0);
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.ramstate = FREE;
`else
    // Without the link register an SC is just a write
    tick();
    bus.ramstate = BUSY;
    drive_d(1'b0, 1'b1, 1'b1, 32'h200, 32'h11);
    push("sc_plain", 1'b1, 32'h0);
    tick();
    sample();
    chk("sc_plain_ramWEN", {31'b0, bus.ramWEN}, 32'd1);
    chk("sc_plain_dwait", {31'b0, bus.dwait}, 32'd1);
    tick();
    bus.ramstate = ACCESS;
    sample();
    tick();
    drive_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.ramstate = FREE;
`endif

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
